// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin arbiter sharing one memory slave between
// the CPU instruction and data ports, with a watchdog that completes any access
// the slave leaves unanswered.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,

  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,

  output logic        slave_valid,
  output logic        slave_instr,
  output logic [31:0] slave_addr,
  output logic [31:0] slave_wdata,
  output logic [3:0]  slave_wstrb,
  input  logic [31:0] slave_rdata,
  input  logic        slave_ready,

  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

  // Counter value seen in the TIMEOUT-th cycle of slave_valid.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 32'd1);
  localparam bit          WdogEn      = (TIMEOUT != 32'd0);

  state_e      state_q;
  logic        last_d_q;
  logic [15:0] cnt_q;
  logic        slave_valid_q;
  logic        slave_instr_q;
  logic [31:0] slave_addr_q;
  logic [31:0] slave_wdata_q;
  logic [3:0]  slave_wstrb_q;

  logic grant_i;
  logic grant_d;
  logic expire;

  // Outputs are gated by rst so a reset mid-grant never leaks a ready pulse.
  always_comb begin
    grant_i       = (state_q == StGrantI) && !rst;
    grant_d       = (state_q == StGrantD) && !rst;
    // A real slave response always beats the watchdog.
    expire        = WdogEn && (grant_i || grant_d) && !slave_ready && (cnt_q == TimeoutLast);
    imemory_ready = grant_i && (slave_ready || expire);
    dmemory_ready = grant_d && (slave_ready || expire);
    imemory_rdata = (grant_i && slave_ready) ? slave_rdata : 32'd0;
    dmemory_rdata = (grant_d && slave_ready) ? slave_rdata : 32'd0;
    timeout_err   = expire;
  end

  assign slave_valid = slave_valid_q;
  assign slave_instr = slave_instr_q;
  assign slave_addr  = slave_addr_q;
  assign slave_wdata = slave_wdata_q;
  assign slave_wstrb = slave_wstrb_q;

  // Arbitration FSM: grant in IDLE, hold the latched request until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_d_q      <= 1'b0;
      cnt_q         <= 16'd0;
      slave_valid_q <= 1'b0;
      slave_instr_q <= 1'b0;
      slave_addr_q  <= 32'd0;
      slave_wdata_q <= 32'd0;
      slave_wstrb_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          // Data wins a tie unless it was the last owner.
          if (dmemory_valid && (!imemory_valid || !last_d_q)) begin
            slave_valid_q <= 1'b1;
            slave_instr_q <= dmemory_instr;
            slave_addr_q  <= dmemory_addr;
            slave_wdata_q <= dmemory_wdata;
            slave_wstrb_q <= dmemory_wstrb;
            last_d_q      <= 1'b1;
            cnt_q         <= 16'd0;
            state_q       <= StGrantD;
          end else if (imemory_valid) begin
            slave_valid_q <= 1'b1;
            slave_instr_q <= imemory_instr;
            slave_addr_q  <= imemory_addr;
            slave_wdata_q <= imemory_wdata;
            slave_wstrb_q <= imemory_wstrb;
            last_d_q      <= 1'b0;
            cnt_q         <= 16'd0;
            state_q       <= StGrantI;
          end
        end
        StGrantI, StGrantD: begin
          if (slave_ready || expire) begin
            slave_valid_q <= 1'b0;
            state_q       <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          slave_valid_q <= 1'b0;
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single access, round-robin,
// write-field latching, watchdog and reset mid-grant.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemory_valid = 1'b0, imemory_instr = 1'b0;
  logic [31:0] imemory_addr = '0, imemory_wdata = '0;
  logic [3:0]  imemory_wstrb = '0;
  logic [31:0] imemory_rdata;
  logic        imemory_ready;
  logic        dmemory_valid = 1'b0, dmemory_instr = 1'b0;
  logic [31:0] dmemory_addr = '0, dmemory_wdata = '0;
  logic [3:0]  dmemory_wstrb = '0;
  logic [31:0] dmemory_rdata;
  logic        dmemory_ready;
  logic        slave_valid, slave_instr;
  logic [31:0] slave_addr, slave_wdata;
  logic [3:0]  slave_wstrb;
  logic [31:0] slave_rdata = '0;
  logic        slave_ready = 1'b0;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .imemory_valid (imemory_valid),
    .imemory_instr (imemory_instr),
    .imemory_addr  (imemory_addr),
    .imemory_wdata (imemory_wdata),
    .imemory_wstrb (imemory_wstrb),
    .imemory_rdata (imemory_rdata),
    .imemory_ready (imemory_ready),
    .dmemory_valid (dmemory_valid),
    .dmemory_instr (dmemory_instr),
    .dmemory_addr  (dmemory_addr),
    .dmemory_wdata (dmemory_wdata),
    .dmemory_wstrb (dmemory_wstrb),
    .dmemory_rdata (dmemory_rdata),
    .dmemory_ready (dmemory_ready),
    .slave_valid   (slave_valid),
    .slave_instr   (slave_instr),
    .slave_addr    (slave_addr),
    .slave_wdata   (slave_wdata),
    .slave_wstrb   (slave_wstrb),
    .slave_rdata   (slave_rdata),
    .slave_ready   (slave_ready),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both masters requesting.
    imemory_valid = 1'b1; imemory_addr = 32'h0000_1000;
    dmemory_valid = 1'b1; dmemory_addr = 32'h0000_2000;
    repeat (3) cyc();
    smp();
    check("rst_svalid", {31'd0, slave_valid}, 32'd0);
    check("rst_iready", {31'd0, imemory_ready}, 32'd0);
    check("rst_dready", {31'd0, dmemory_ready}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    check("rst_saddr", slave_addr, 32'd0);
    check("rst_irdata", imemory_rdata, 32'd0);
    cyc(); rst = 1'b0;
    cyc(); smp();
    check("first_grant_valid", {31'd0, slave_valid}, 32'd1);
    check("first_grant_is_d", slave_addr, 32'h0000_2000);
    check("first_no_ready", {31'd0, dmemory_ready}, 32'd0);
    cyc(); slave_ready = 1'b1; slave_rdata = 32'hCAFE_0001; smp();
    check("first_dready", {31'd0, dmemory_ready}, 32'd1);
    check("first_drdata", dmemory_rdata, 32'hCAFE_0001);
    check("first_iready", {31'd0, imemory_ready}, 32'd0);
    check("first_irdata", imemory_rdata, 32'd0);
    cyc(); slave_ready = 1'b0; imemory_valid = 1'b0; dmemory_valid = 1'b0; smp();
    check("first_turn_svalid", {31'd0, slave_valid}, 32'd0);
    check("first_turn_dready", {31'd0, dmemory_ready}, 32'd0);

    // Single master, fast slave.
    cyc(); imemory_valid = 1'b1; imemory_addr = 32'h0000_0100; smp();
    check("fast_idle_svalid", {31'd0, slave_valid}, 32'd0);
    cyc(); slave_ready = 1'b1; slave_rdata = 32'hDEAD_BEEF; smp();
    check("fast_svalid", {31'd0, slave_valid}, 32'd1);
    check("fast_saddr", slave_addr, 32'h0000_0100);
    check("fast_iready", {31'd0, imemory_ready}, 32'd1);
    check("fast_irdata", imemory_rdata, 32'hDEAD_BEEF);
    check("fast_dready", {31'd0, dmemory_ready}, 32'd0);
    cyc(); imemory_valid = 1'b0; slave_ready = 1'b0; smp();
    check("fast_turn_iready", {31'd0, imemory_ready}, 32'd0);
    check("fast_turn_svalid", {31'd0, slave_valid}, 32'd0);

    // Round-robin with a 3-cycle slave: D, I, D, I.
    cyc();
    imemory_valid = 1'b1; imemory_addr = 32'h1111_0000;
    dmemory_valid = 1'b1; dmemory_addr = 32'h2222_0000;
    for (int k = 0; k < 4; k++) begin
      logic own_d;
      own_d = (k % 2 == 0);
      cyc(); smp();
      check("rr_svalid", {31'd0, slave_valid}, 32'd1);
      check("rr_saddr", slave_addr, own_d ? 32'h2222_0000 : 32'h1111_0000);
      cyc(); smp();
      check("rr_wait_ready", {30'd0, imemory_ready, dmemory_ready}, 32'd0);
      cyc(); slave_ready = 1'b1; slave_rdata = 32'h0000_0A00 + k; smp();
      check("rr_ready_owner", {30'd0, imemory_ready, dmemory_ready}, own_d ? 32'd1 : 32'd2);
      check("rr_rdata", own_d ? dmemory_rdata : imemory_rdata, 32'h0000_0A00 + k);
      cyc(); slave_ready = 1'b0;
      if (k == 3) begin
        imemory_valid = 1'b0; dmemory_valid = 1'b0;
      end
      smp();
      check("rr_pulse_1cyc", {30'd0, imemory_ready, dmemory_ready}, 32'd0);
      check("rr_turn_svalid", {31'd0, slave_valid}, 32'd0);
    end

    // Write fields latched and held, even as the master changes its inputs.
    cyc();
    dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = 32'h0010_0004;
    dmemory_wdata = 32'h1234_5678; dmemory_wstrb = 4'h3;
    cyc(); smp();
    check("wr_svalid", {31'd0, slave_valid}, 32'd1);
    check("wr_saddr", slave_addr, 32'h0010_0004);
    check("wr_swdata", slave_wdata, 32'h1234_5678);
    check("wr_swstrb", {28'd0, slave_wstrb}, 32'h3);
    check("wr_sinstr", {31'd0, slave_instr}, 32'd0);
    cyc();
    dmemory_valid = 1'b0; dmemory_addr = 32'hFFFF_FFFF; dmemory_wdata = 32'd0;
    dmemory_wstrb = 4'hF; dmemory_instr = 1'b1;
    smp();
    check("wr_hold_addr", slave_addr, 32'h0010_0004);
    check("wr_hold_wdata", slave_wdata, 32'h1234_5678);
    check("wr_hold_svalid", {31'd0, slave_valid}, 32'd1);
    cyc(); slave_ready = 1'b1; slave_rdata = 32'h0000_0055; smp();
    check("wr_hold_wstrb", {28'd0, slave_wstrb}, 32'h3);
    check("wr_dropped_still_ready", {31'd0, dmemory_ready}, 32'd1);
    cyc(); slave_ready = 1'b0; smp();
    check("wr_turn_svalid", {31'd0, slave_valid}, 32'd0);

    // Watchdog: slave never answers.
    dmemory_instr = 1'b0; dmemory_wstrb = 4'h0;
    cyc(); dmemory_valid = 1'b1; dmemory_addr = 32'h0000_3000; slave_rdata = 32'h0BAD_0BAD;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 8) dmemory_valid = 1'b0;
      smp();
      if (c < 8) begin
        check("wd_wait", {30'd0, dmemory_ready, timeout_err}, 32'd0);
      end else begin
        check("wd_dready", {31'd0, dmemory_ready}, 32'd1);
        check("wd_drdata_zero", dmemory_rdata, 32'd0);
        check("wd_tmo", {31'd0, timeout_err}, 32'd1);
        check("wd_iready", {31'd0, imemory_ready}, 32'd0);
      end
    end
    cyc(); smp();
    check("wd_idle_svalid", {31'd0, slave_valid}, 32'd0);
    check("wd_idle_tmo", {31'd0, timeout_err}, 32'd0);

    // Watchdog: slave answers exactly in cycle 8, response wins.
    cyc(); dmemory_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 8) begin
        slave_ready = 1'b1; slave_rdata = 32'hA5A5_0008; dmemory_valid = 1'b0;
      end
      smp();
      if (c == 8) begin
        check("wd8_dready", {31'd0, dmemory_ready}, 32'd1);
        check("wd8_drdata", dmemory_rdata, 32'hA5A5_0008);
        check("wd8_tmo", {31'd0, timeout_err}, 32'd0);
      end
    end
    cyc(); slave_ready = 1'b0; smp();
    check("wd8_idle_svalid", {31'd0, slave_valid}, 32'd0);

    // Reset in cycle 2 of an access.
    cyc(); imemory_valid = 1'b1; imemory_addr = 32'h0000_4000;
    cyc(); smp();
    check("rmg_svalid", {31'd0, slave_valid}, 32'd1);
    cyc(); rst = 1'b1; smp();
    check("rmg_no_ready", {31'd0, imemory_ready}, 32'd0);
    cyc(); rst = 1'b0; imemory_valid = 1'b0; slave_ready = 1'b1; slave_rdata = 32'h7777_7777;
    smp();
    check("rmg_svalid_low", {31'd0, slave_valid}, 32'd0);
    check("rmg_stray_ready", {30'd0, imemory_ready, dmemory_ready}, 32'd0);
    check("rmg_stray_rdata", imemory_rdata | dmemory_rdata, 32'd0);
    cyc(); slave_ready = 1'b0; smp();
    check("rmg_stay_idle", {31'd0, slave_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
